// File: rtl/watch_fnd_pkg.sv
// Shared constants for the watch 7-segment display stage: segment codes (active-low
// {dp,g,f,e,d,c,b,a}), field encodings, display modes and decimal digit helpers.
package watch_fnd_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [1:0] FLD_MSEC = 2'd0;
    localparam logic [1:0] FLD_SEC  = 2'd1;
    localparam logic [1:0] FLD_MIN  = 2'd2;
    localparam logic [1:0] FLD_HOUR = 2'd3;

    localparam logic MODE_SEC_MSEC = 1'b0;
    localparam logic MODE_HOUR_MIN = 1'b1;

    // Inputs are at most 127, so tens never exceeds 12 and fits in 4 bits.
    function automatic logic [3:0] tens_digit(input logic [6:0] value);
        return 4'(value / 7'd10);
    endfunction

    function automatic logic [3:0] ones_digit(input logic [6:0] value);
        return 4'(value % 7'd10);
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational decimal digit to active-low 7-segment code; digits above 9 are blank.
module bcd_to_seg
    import watch_fnd_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       dp,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        if (dp) begin
            seg[7] = 1'b0;
        end
    end

endmodule

// File: rtl/watch_fnd_ctrl.sv
// Basys3 4-digit scanned display driver showing sec.msec or hour.min from a per-frame snapshot.
// Optional field blinking is enabled by defining WATCH_FND_BLINK_EN.
module watch_fnd_ctrl
    import watch_fnd_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 100_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] msec,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic [4:0] hour,
    input  logic       disp_mode,
    input  logic [1:0] time_select,
    output logic [3:0] fnd_com,
    output logic [7:0] fnd_data
);

    localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);

    logic [CntW-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]      digit_sel_q, digit_sel_d;
    logic [6:0]      snap_msec_q, snap_msec_d;
    logic [5:0]      snap_sec_q, snap_sec_d;
    logic [5:0]      snap_min_q, snap_min_d;
    logic [4:0]      snap_hour_q, snap_hour_d;
    logic            snap_mode_q, snap_mode_d;
    logic [1:0]      snap_tsel_q, snap_tsel_d;
    logic [3:0]      fnd_com_d;
    logic [7:0]      fnd_data_d;

    logic            digit_end;
    logic            frame_end;
    logic [6:0]      field_hi;
    logic [6:0]      field_lo;
    logic [6:0]      field_val;
    logic [3:0]      digit_val;
    logic            dp_lit;
    logic            field_blank;
    logic [7:0]      seg_code;

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_q  <= '0;
            digit_sel_q <= 2'd0;
            snap_msec_q <= '0;
            snap_sec_q  <= '0;
            snap_min_q  <= '0;
            snap_hour_q <= '0;
            snap_mode_q <= MODE_SEC_MSEC;
            snap_tsel_q <= FLD_MSEC;
            fnd_com     <= 4'b1111;
            fnd_data    <= SEG_BLANK;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            digit_sel_q <= digit_sel_d;
            snap_msec_q <= snap_msec_d;
            snap_sec_q  <= snap_sec_d;
            snap_min_q  <= snap_min_d;
            snap_hour_q <= snap_hour_d;
            snap_mode_q <= snap_mode_d;
            snap_tsel_q <= snap_tsel_d;
            fnd_com     <= fnd_com_d;
            fnd_data    <= fnd_data_d;
        end
    end

    // Snapshot loads on the last cycle of digit 3 so a whole frame shows one consistent time.
    always_comb begin
        digit_end   = (scan_cnt_q == CntMax);
        frame_end   = digit_end && (digit_sel_q == 2'd3);
        scan_cnt_d  = digit_end ? '0 : scan_cnt_q + 1'b1;
        digit_sel_d = digit_end ? digit_sel_q + 2'd1 : digit_sel_q;
        snap_msec_d = snap_msec_q;
        snap_sec_d  = snap_sec_q;
        snap_min_d  = snap_min_q;
        snap_hour_d = snap_hour_q;
        snap_mode_d = snap_mode_q;
        snap_tsel_d = snap_tsel_q;
        if (frame_end) begin
            snap_msec_d = msec;
            snap_sec_d  = sec;
            snap_min_d  = min;
            snap_hour_d = hour;
            snap_mode_d = disp_mode;
            snap_tsel_d = time_select;
        end
    end

    always_comb begin
        if (snap_mode_q == MODE_HOUR_MIN) begin
            field_hi = {2'b00, snap_hour_q};
            field_lo = {1'b0, snap_min_q};
        end else begin
            field_hi = {1'b0, snap_sec_q};
            field_lo = snap_msec_q;
        end
        field_val = digit_sel_q[1] ? field_hi : field_lo;
        digit_val = digit_sel_q[0] ? tens_digit(field_val) : ones_digit(field_val);
        dp_lit    = (digit_sel_q == 2'd2) && (snap_msec_q < 7'd50);
    end

    bcd_to_seg u_bcd_to_seg (
        .digit (digit_val),
        .dp    (dp_lit),
        .seg   (seg_code)
    );

`ifdef WATCH_FND_BLINK_EN
    logic [1:0] shown_fld;

    always_comb begin
        if (snap_mode_q == MODE_HOUR_MIN) begin
            shown_fld = digit_sel_q[1] ? FLD_HOUR : FLD_MIN;
        end else begin
            shown_fld = digit_sel_q[1] ? FLD_SEC : FLD_MSEC;
        end
        field_blank = (snap_msec_q >= 7'd50) && (shown_fld == snap_tsel_q);
    end
`else
    logic unused_tsel;

    assign unused_tsel = ^snap_tsel_q;

    always_comb begin
        field_blank = 1'b0;
    end
`endif

    always_comb begin
        fnd_com_d = 4'b1111;
        unique case (digit_sel_q)
            2'd0: fnd_com_d = 4'b1110;
            2'd1: fnd_com_d = 4'b1101;
            2'd2: fnd_com_d = 4'b1011;
            2'd3: fnd_com_d = 4'b0111;
            default: fnd_com_d = 4'b1111;
        endcase
        fnd_data_d = field_blank ? SEG_BLANK : seg_code;
    end

endmodule

// File: tb/tb_watch_fnd_ctrl.sv
// Self-checking bench for watch_fnd_ctrl: frame-level display model plus directed frame checks.
module tb_watch_fnd_ctrl;

    localparam int unsigned SD = 4;
    localparam int FRAME = 4 * SD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] msec = '0;
    logic [5:0] sec = '0;
    logic [5:0] min = '0;
    logic [4:0] hour = '0;
    logic       disp_mode = 1'b0;
    logic [1:0] time_select = 2'd0;
    logic [3:0] fnd_com;
    logic [7:0] fnd_data;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    watch_fnd_ctrl #(
        .SCAN_DIV (SD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .msec        (msec),
        .sec         (sec),
        .min         (min),
        .hour        (hour),
        .disp_mode   (disp_mode),
        .time_select (time_select),
        .fnd_com     (fnd_com),
        .fnd_data    (fnd_data)
    );

    // Reference model: edges since reset, digit = which quarter of the frame, frame values
    // taken from the inputs present at the last edge of the previous frame.
    int         e_cnt = 0;
    bit         model_valid = 1'b0;
    logic [3:0] exp_com;
    logic [7:0] exp_data;
    int         m_msec, m_sec, m_min, m_hour, m_mode, m_tsel;

    function automatic logic [6:0] seg_of(input int n);
        case (n)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    always @(posedge clk) begin : model
        int  s, pos, v, n, fld;
        bit  blank;
        if (rst) begin
            e_cnt = 0;
            m_msec = 0; m_sec = 0; m_min = 0; m_hour = 0; m_mode = 0; m_tsel = 0;
            exp_com = 4'b1111;
            exp_data = 8'hFF;
            model_valid = 1'b1;
        end else begin
            s = e_cnt;
            e_cnt++;
            pos = (s / SD) % 4;
            if (pos >= 2) v = (m_mode != 0) ? m_hour : m_sec;
            else          v = (m_mode != 0) ? m_min : m_msec;
            n = (pos % 2 == 1) ? v / 10 : v % 10;
            exp_com = 4'b1111 ^ 4'(1 << pos);
            exp_data = {!(pos == 2 && m_msec < 50), seg_of(n)};
            blank = 1'b0;
`ifdef WATCH_FND_BLINK_EN
            if (m_mode != 0) fld = (pos >= 2) ? 3 : 2;
            else             fld = (pos >= 2) ? 1 : 0;
            blank = (m_msec >= 50) && (m_tsel == fld);
`else
            fld = 0;
`endif
            if (blank) exp_data = 8'hFF;
            if (s % FRAME == FRAME - 1) begin
                m_msec = int'(msec); m_sec = int'(sec); m_min = int'(min);
                m_hour = int'(hour); m_mode = int'(disp_mode); m_tsel = int'(time_select);
            end
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            n_checks++;
            if (fnd_com !== exp_com || fnd_data !== exp_data) begin
                n_fail++;
                $display("FAIL model t=%0t: com=%b data=%h, required com=%b data=%h",
                         $time, fnd_com, fnd_data, exp_com, exp_data);
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s t=%0t: got %h, required %h", name, $time, act, req);
        end
    endtask

    // Step to the negedge just after the first edge of a frame (digit 0 visible).
    task automatic next_frame();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(e_cnt > 0 && (e_cnt - 1) % FRAME == 0) && k < 3 * FRAME);
        if (k >= 3 * FRAME) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_wait: got timeout, required frame start");
        end
    endtask

    task automatic check_frame(input string name, input logic [7:0] d3, input logic [7:0] d2,
                               input logic [7:0] d1, input logic [7:0] d0);
        next_frame();
        chk({name, " d0"}, fnd_data, d0);
        chk({name, " com0"}, {4'h0, fnd_com}, 8'h0E);
        repeat (SD) @(negedge clk);
        chk({name, " d1"}, fnd_data, d1);
        repeat (SD) @(negedge clk);
        chk({name, " d2"}, fnd_data, d2);
        repeat (SD) @(negedge clk);
        chk({name, " d3"}, fnd_data, d3);
        chk({name, " com3"}, {4'h0, fnd_com}, 8'h07);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset com", {4'h0, fnd_com}, 8'h0F);
        chk("reset data", fnd_data, 8'hFF);
        rst = 1'b0;
        @(negedge clk);
        chk("first com", {4'h0, fnd_com}, 8'h0E);
        chk("first data", fnd_data, 8'hC0);
        repeat (SD) @(negedge clk);
        chk("rotate com", {4'h0, fnd_com}, 8'h0D);

        sec = 6'd37;
        msec = 7'd8;
        next_frame();
        check_frame("mode0", 8'hB0, 8'h78, 8'hC0, 8'h80);

        hour = 5'd12;
        min = 6'd5;
        disp_mode = 1'b1;
        msec = 7'd60;
        next_frame();
        check_frame("mode1", 8'hF9, 8'hA4, 8'hC0, 8'h92);

        disp_mode = 1'b0;
        msec = 7'd8;
        next_frame();
        next_frame();
        chk("stable d0", fnd_data, 8'h80);
        repeat (SD) @(negedge clk);
        chk("stable d1", fnd_data, 8'hC0);
        sec = 6'd41;
        repeat (SD) @(negedge clk);
        chk("stable d2", fnd_data, 8'h78);
        repeat (SD) @(negedge clk);
        chk("stable d3", fnd_data, 8'hB0);
        check_frame("stable new", 8'h99, 8'h79, 8'hC0, 8'h80);

        msec = 7'd127;
        time_select = 2'd3;
        next_frame();
        check_frame("out of range", 8'h99, 8'hF9, 8'hFF, 8'hF8);

        time_select = 2'd1;
        msec = 7'd70;
        next_frame();
`ifdef WATCH_FND_BLINK_EN
        check_frame("blink on", 8'hFF, 8'hFF, 8'hF8, 8'hC0);
`else
        check_frame("no blink", 8'h99, 8'hF9, 8'hF8, 8'hC0);
`endif
        msec = 7'd20;
        next_frame();
        check_frame("blink off phase", 8'h99, 8'h79, 8'hA4, 8'hC0);
        disp_mode = 1'b1;
        msec = 7'd70;
        next_frame();
        check_frame("blink hidden field", 8'hF9, 8'hA4, 8'hC0, 8'h92);

        next_frame();
        repeat (SD + 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midscan reset com", {4'h0, fnd_com}, 8'h0F);
        chk("midscan reset data", fnd_data, 8'hFF);
        rst = 1'b0;
        @(negedge clk);
        chk("after reset com", {4'h0, fnd_com}, 8'h0E);
        chk("after reset data", fnd_data, 8'hC0);
        repeat (FRAME) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
